// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results land in HI/LO on the edge where the busy counter reaches zero.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt;
    logic [3:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;

    logic        is_md;
    logic        accept;
    logic        mt_ok;
    logic        res_we;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        dvs;
    logic [31:0]        dvu;
    logic signed [31:0] qs;
    logic signed [31:0] rs;
    logic [31:0]        qu;
    logic [31:0]        ru;
    logic               ovf;

    assign Busy   = (cnt != '0);
    assign is_md  = (MDUOp >= 4'd1) && (MDUOp <= 4'd4);
    assign accept = Start && is_md && !Req && !Busy;
    assign mt_ok  = !Req && !Busy;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};

    // Substituting 1 as divisor covers both /0 (result discarded) and
    // the -2^31 / -1 overflow, where quotient = dividend and remainder = 0.
    assign ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign dvs = ((b_q == '0) || ovf) ? 32'd1 : b_q;
    assign dvu = (b_q == '0) ? 32'd1 : b_q;
    assign qs  = $signed(a_q) / $signed(dvs);
    assign rs  = $signed(a_q) % $signed(dvs);
    assign qu  = a_q / dvu;
    assign ru  = a_q % dvu;

    always_comb begin
        res_we = 1'b0;
        res_hi = HI;
        res_lo = LO;
        case (op_q)
            4'd1: begin
                res_we = 1'b1;
                {res_hi, res_lo} = prod_s;
            end
            4'd2: begin
                res_we = 1'b1;
                {res_hi, res_lo} = prod_u;
            end
            4'd3: begin
                res_we = (b_q != '0);
                res_hi = rs;
                res_lo = qs;
            end
            4'd4: begin
                res_we = (b_q != '0);
                res_hi = ru;
                res_lo = qu;
            end
            default: res_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            HI   <= '0;
            LO   <= '0;
        end else begin
            if (accept) begin
                cnt  <= (MDUOp <= 4'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                op_q <= MDUOp;
                a_q  <= A;
                b_q  <= B;
            end else if (Busy) begin
                cnt <= cnt - 1'b1;
            end
            if ((cnt == CW'(1)) && res_we) begin
                HI <= res_hi;
                LO <= res_lo;
            end else if (mt_ok && (MDUOp == 4'd5)) begin
                HI <= A;
            end else if (mt_ok && (MDUOp == 4'd6)) begin
                LO <= A;
            end
        end
    end

    always_comb begin
        Out = '0;
        unique case (1'b1)
            (MDUOp == 4'd7): Out = HI;
            (MDUOp == 4'd8): Out = LO;
            default:         Out = '0;
        endcase
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, Busy duration of mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, Busy duration of div/divu.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port Req  input  1  exception/interrupt flush; squashes the E-stage instruction in the same cycle.
REQ-006 SHALL have port Start  input  1  E-stage instruction is mult/multu/div/divu.
REQ-007 SHALL have port MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, others none.
REQ-008 SHALL have port A  input  32  forwarded rs operand.
REQ-009 SHALL have port B  input  32  forwarded rt operand.
REQ-010 SHALL have port Busy  output  1  operation in progress; consumed by the stall logic.
REQ-011 SHALL have port HI  output  32  architectural HI register.
REQ-012 SHALL have port LO  output  32  architectural LO register.
REQ-013 SHALL have port Out  output  32  mfhi/mflo read data.

Function
REQ-014 SHALL accept an operation at a rising edge only when Start=1, MDUOp in 1..4, Req=0 and Busy=0; operands A, B latched at that edge.
REQ-015 SHALL on acceptance load an internal counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4); Busy = (counter != 0).
REQ-016 SHALL decrement the counter once per edge while nonzero; Busy high exactly N cycles after the accept edge, low in cycle N+1.
REQ-017 SHALL write HI/LO at the edge where the counter goes 1->0; new values visible the cycle Busy falls, never earlier.
REQ-018 mult: {HI,LO} = signed 64-bit product of A*B; multu: unsigned 64-bit product.
REQ-019 div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-020 SHALL for div/divu with B=0 run full DIV_CYCLES with Busy and leave HI/LO unchanged.
REQ-021 SHALL for div with A=0x8000_0000, B=0xFFFF_FFFF give LO=0x8000_0000, HI=0.
REQ-022 SHALL write HI<=A (op 5) or LO<=A (op 6) at the edge when Req=0 and Busy=0; one-cycle effect, no Busy.
REQ-023 SHALL ignore Start, mthi, mtlo while Busy=1 (stall logic prevents; block still protects state).
REQ-024 SHALL squash any Start/mthi/mtlo presented with Req=1: no state change.
REQ-025 SHALL let an operation already in progress finish normally when Req asserts (it belongs to an older, committed instruction).
REQ-026 Out SHALL be combinational: HI when MDUOp=7, LO when MDUOp=8, else 0; reflects current register values, independent of Busy.
REQ-027 SHALL compute results from latched operands only; A/B changes after acceptance have no effect.

Reset
REQ-028 SHALL on reset=1 at an edge set HI=0, LO=0, counter=0, Busy=0, discard any in-flight result, overriding all other inputs.
REQ-029 SHALL output Out=0 while MDUOp is not 7/8 after reset.

Verification
REQ-030 mult A=0xFFFF_FFFF B=2, Start one cycle -> Busy high 5 cycles, then HI=0xFFFF_FFFF LO=0xFFFF_FFFE; multu same operands -> HI=1 LO=0xFFFF_FFFE.
REQ-031 div A=0xFFFF_FFF9 (-7) B=2 -> Busy 10 cycles, LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; divu A=7 B=2 -> LO=3 HI=1.
REQ-032 mthi A=0x1234_5678 then mfhi next cycle -> HI and Out=0x1234_5678, Busy never set; div by zero afterward -> HI unchanged after 10 Busy cycles.
REQ-033 Start(mult) with Req=1 same cycle -> Busy stays 0, HI/LO unchanged; Req pulse in cycle 3 of running div -> div completes with correct result.
REQ-034 reset asserted in cycle 4 of a running mult -> next cycle Busy=0, HI=LO=0, no later write occurs.
REQ-035 Start(divu) while Busy from mult, and mtlo while Busy -> both ignored; only mult result written at its completion.
